// File: rtl/tau_stage_scheduler.sv
// ============================================================================
// Module   : tau_stage_scheduler
// Purpose  : Base-sample counter, request latch, arbiter and burst sequencer
//            for a cascade of correlator shift-RAM stages sharing one MAC.
//            Optional macro TAU_STAGE_SCHED_RR_EN selects round-robin grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tau_stage_scheduler #(
    parameter int NSTAGE    = 4,
    parameter int BURST_LEN = 130,
    parameter int CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      sample_in,
    output logic [NSTAGE-1:0]         stage_sin,
    output logic [$clog2(NSTAGE)-1:0] mac_sel,
    output logic                      mac_busy,
    output logic                      mac_done,
    output logic [NSTAGE-1:0]         pend,
    output logic [NSTAGE-1:0]         overrun,
    input  logic                      ovr_clr
);

    localparam int SEL_W = $clog2(NSTAGE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NSTAGE-1:0] scnt_q, scnt_d;
    logic [NSTAGE-1:0] pend_q, pend_d;
    logic [NSTAGE-1:0] ovr_q, ovr_d;
    logic [NSTAGE-1:0] sin_q, sin_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  bcnt_q, bcnt_d;
`ifdef TAU_STAGE_SCHED_RR_EN
    logic [SEL_W-1:0]  last_q, last_d;
    logic              rr_found;
    int                rr_j;
`endif

    logic              w_samp;
    logic [NSTAGE-1:0] w_scnt_nx;
    logic [NSTAGE-1:0] w_req;
    logic [SEL_W-1:0]  w_gidx;
    logic [NSTAGE-1:0] w_gvec;
    logic [NSTAGE-1:0] w_clr;
    logic [NSTAGE-1:0] w_ovr_set;

    // Stage k fires when the low k bits of the updated count roll to zero.
    always_comb begin
        w_samp    = sample_in & en;
        w_scnt_nx = scnt_q + 1'b1;
        w_req     = '0;
        w_req[0]  = w_samp;
        for (int k = 1; k < NSTAGE; k++) begin
            w_req[k] = w_samp && ((w_scnt_nx & NSTAGE'((1 << k) - 1)) == '0);
        end
        scnt_d = w_samp ? w_scnt_nx : scnt_q;
    end

    always_comb begin
        w_gidx = '0;
`ifdef TAU_STAGE_SCHED_RR_EN
        rr_found = 1'b0;
        rr_j     = 0;
        for (int i = 0; i < NSTAGE; i++) begin
            rr_j = (int'(last_q) + 1 + i) % NSTAGE;
            if (!rr_found && pend_q[SEL_W'(rr_j)]) begin
                rr_found = 1'b1;
                w_gidx   = SEL_W'(rr_j);
            end
        end
`else
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                w_gidx = SEL_W'(i);
            end
        end
`endif
        w_gvec         = '0;
        w_gvec[w_gidx] = 1'b1;
    end

    // A request arriving on the grant edge re-sets the bit; it is not an overrun.
    always_comb begin
        w_clr     = (state_q == S_GRANT) ? w_gvec : '0;
        w_ovr_set = w_req & pend_q & ~w_clr;
        pend_d    = (pend_q & ~w_clr) | w_req;
        ovr_d     = (ovr_clr ? '0 : ovr_q) | w_ovr_set;
    end

    always_comb begin
        state_d = state_q;
        sin_d   = '0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        sel_d   = sel_q;
        bcnt_d  = bcnt_q;
`ifdef TAU_STAGE_SCHED_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                sin_d   = w_gvec;
                sel_d   = w_gidx;
                busy_d  = 1'b1;
                bcnt_d  = CNT_W'(BURST_LEN - 1);
                state_d = S_BURST;
`ifdef TAU_STAGE_SCHED_RR_EN
                last_d  = w_gidx;
`endif
            end
            S_BURST: begin
                if (bcnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    bcnt_d = bcnt_q - 1'b1;
                    // Registered, so raise it one edge early to overlap the final busy cycle.
                    done_d = (bcnt_q == CNT_W'(1));
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            scnt_q  <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
            sin_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcnt_q  <= '0;
`ifdef TAU_STAGE_SCHED_RR_EN
            last_q  <= SEL_W'(NSTAGE - 1);
`endif
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            sin_q   <= sin_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcnt_q  <= bcnt_d;
`ifdef TAU_STAGE_SCHED_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign stage_sin = sin_q;
    assign mac_sel   = sel_q;
    assign mac_busy  = busy_q;
    assign mac_done  = done_q;
    assign pend      = pend_q;
    assign overrun   = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_tau_stage_scheduler.sv
// ============================================================================
// Module   : tb_tau_stage_scheduler
// Purpose  : Directed self-checking bench for tau_stage_scheduler
//            (NSTAGE=4, BURST_LEN=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tau_stage_scheduler;

    localparam int T2_PEND [8]  = '{1, 3, 1, 7, 5, 3, 1, 15};
    localparam int T2_ORD  [15] = '{0, 0, 1, 0, 0, 1, 0, 2, 0, 1, 0, 0, 1, 2, 3};

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       sample_in;
    logic       ovr_clr;
    logic [3:0] stage_sin;
    logic [1:0] mac_sel;
    logic       mac_busy;
    logic       mac_done;
    logic [3:0] pend;
    logic [3:0] overrun;

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int viol   = 0;
    int glog_idx [$];
    int glog_cyc [$];
    logic prev_sin  = 1'b0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    tau_stage_scheduler #(
        .NSTAGE   (4),
        .BURST_LEN(8),
        .CNT_W    (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sample_in(sample_in),
        .stage_sin(stage_sin),
        .mac_sel  (mac_sel),
        .mac_busy (mac_busy),
        .mac_done (mac_done),
        .pend     (pend),
        .overrun  (overrun),
        .ovr_clr  (ovr_clr)
    );

    // Grant log plus one-hot / single-cycle strobe watch.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (stage_sin != 4'b0) begin
            if ($countones(stage_sin) != 1 || prev_sin) viol++;
            for (int i = 0; i < 4; i++) if (stage_sin[i]) glog_idx.push_back(i);
            glog_cyc.push_back(cyc);
        end
        if (mac_done && prev_done) viol++;
        prev_sin  = |stage_sin;
        prev_done = mac_done;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        sample_in = 1'b0;
        ovr_clr   = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic pulse_sample();
        sample_in = 1'b1;
        tick(1);
        sample_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound, output int busy_n, output int done_at);
        busy_n  = 0;
        done_at = 0;
        for (int i = 0; i < bound && mac_busy; i++) begin
            busy_n++;
            if (mac_done) done_at = busy_n;
            tick(1);
        end
        chk({tag, "_busy_end"}, mac_busy, 0);
    endtask

    initial begin
        int b, d, base, n0;
        rst = 1'b1; en = 1'b0; sample_in = 1'b0; ovr_clr = 1'b0;
        tick(2);
        chk("rst_outputs", {stage_sin, mac_sel, mac_busy, mac_done, pend, overrun}, 0);
        rst = 1'b0;
        tick(1);
        en = 1'b1;

        // 1: single sample, latency and burst length
        pulse_sample();
        chk("t1_pend", pend, 4'b0001);
        chk("t1_sin_n1", stage_sin, 0);
        tick(1);
        chk("t1_sin_n1b", stage_sin, 0);
        tick(1);
        chk("t1_sin_n2", stage_sin, 4'b0001);
        chk("t1_pend_clr", pend, 0);
        wait_idle("t1", 20, b, d);
        chk("t1_busy_len", b, 8);
        chk("t1_done_at", d, 8);
        chk("t1_done_low", mac_done, 0);
        chk("t1_ovr", overrun, 0);

        // 2: eight samples 20 cycles apart
        do_reset();
        base = glog_idx.size();
        for (int s = 0; s < 8; s++) begin
            pulse_sample();
            chk($sformatf("t2_pend%0d", s), pend, T2_PEND[s]);
            tick(19);
        end
        tick(20);
        chk("t2_ngrant", glog_idx.size() - base, 15);
        chk("t2_ovr", overrun, 0);
`ifndef TAU_STAGE_SCHED_RR_EN
        if (glog_idx.size() - base >= 15) begin
            for (int g = 0; g < 15; g++) chk($sformatf("t2_ord%0d", g), glog_idx[base + g], T2_ORD[g]);
            for (int g = 12; g < 15; g++)
                chk($sformatf("t2_gap%0d", g), glog_cyc[base + g] - glog_cyc[base + g - 1], 10);
        end
        chk("t2_sel_hold", mac_sel, 3);
`endif

        // 3: overrun merge, clear, clear-vs-set and grant-vs-set
        do_reset();
        chk("t3_rst_sel", mac_sel, 0);
        pulse_sample();
        tick(2);
        chk("t3_sin", stage_sin, 4'b0001);
        tick(1);
        pulse_sample();
        chk("t3_pend_a", pend, 4'b0011);
        chk("t3_ovr_a", overrun, 0);
        tick(2);
        pulse_sample();
        chk("t3_ovr_b", overrun, 4'b0001);
        chk("t3_pend_b", pend, 4'b0011);
        tick(2);
        ovr_clr = 1'b1;
        pulse_sample();
        chk("t3_ovr_clr_set", overrun, 4'b0011);
        chk("t3_pend_c", pend, 4'b0111);
        tick(1);
        ovr_clr = 1'b0;
        chk("t3_ovr_clr", overrun, 0);
        pulse_sample();
        chk("t3_grant_set_sin", stage_sin, 4'b0001);
        chk("t3_grant_set_pend", pend, 4'b0111);
        chk("t3_grant_set_ovr", overrun, 0);

        // 4: asynchronous reset mid-burst
        tick(10);
`ifndef TAU_STAGE_SCHED_RR_EN
        chk("t4_sin", stage_sin, 4'b0001);
        chk("t4_pend", pend, 4'b0110);
`endif
        tick(3);
        chk("t4_busy_pre", mac_busy, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("t4_async", {stage_sin, mac_sel, mac_busy, mac_done, pend, overrun}, 0);
        tick(1);
        rst = 1'b0;
        n0 = glog_idx.size();
        tick(15);
        chk("t4_no_grant", glog_idx.size() - n0, 0);
        chk("t4_idle", {mac_busy, pend}, 0);

        // 5: en=0 ignores samples, burst still completes
        pulse_sample();
        chk("t5_pend", pend, 4'b0001);
        n0 = glog_idx.size();
        tick(2);
        chk("t5_sin", stage_sin, 4'b0001);
        en = 1'b0;
        pulse_sample();
        pulse_sample();
        pulse_sample();
        chk("t5_pend_en0", pend, 0);
        wait_idle("t5", 20, b, d);
        chk("t5_busy_rest", b, 5);
        chk("t5_done_at", d, 5);
        chk("t5_ngrant", glog_idx.size() - n0, 1);
        en = 1'b1;
        tick(1);
        pulse_sample();
        chk("t5_scnt", pend, 4'b0011);
        tick(25);

        // 6: saturated requests, fixed priority starves, round-robin rotates
        do_reset();
        base = glog_idx.size();
        sample_in = 1'b1;
        tick(60);
        sample_in = 1'b0;
        chk("t6_ovr0", overrun[0], 1);
        tick(50);
        chk("t6_ngrant", (glog_idx.size() - base) >= 6, 1);
        if (glog_idx.size() - base >= 6) begin
            for (int g = 0; g < 6; g++) begin
`ifdef TAU_STAGE_SCHED_RR_EN
                chk($sformatf("t6_rr%0d", g), glog_idx[base + g], g % 4);
`else
                chk($sformatf("t6_fp%0d", g), glog_idx[base + g], 0);
`endif
            end
        end

        chk("strobe_rules", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tau_stage_scheduler.md
Name: tau_stage_scheduler

Overview:
Sequences a cascade of NSTAGE correlator shift-RAM stages that share one downstream multiply-accumulate datapath. Stage k samples every 2^k base samples. Each stage's shift burst occupies the shared datapath for BURST_LEN cycles, so only one stage may burst at a time. The block counts base samples, latches per-stage requests, arbitrates, issues a one-cycle sync strobe to the granted stage, and tracks burst occupancy and overruns.

Parameters:
NSTAGE, 4, number of shift-RAM stages (2..8)
BURST_LEN, 130, cycles one stage's burst occupies the shared datapath (1 sync + 128 shift + 1 flush); minimum 2
CNT_W, 8, width of the burst-length counter; must satisfy 2^CNT_W > BURST_LEN

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  accept new sample strobes when high
sample_in  in  1  one-cycle strobe per base-rate sample
stage_sin  out  NSTAGE  one-hot, one-cycle sync strobe to the granted stage
mac_sel  out  $clog2(NSTAGE)  index of the stage owning the datapath; holds after a burst ends
mac_busy  out  1  high while a burst occupies the datapath
mac_done  out  1  one-cycle pulse on the last burst cycle
pend  out  NSTAGE  latched, not-yet-served requests
overrun  out  NSTAGE  sticky per-stage overrun flags
ovr_clr  in  1  synchronous clear of overrun

Behaviour:
- Reset (asynchronous, rst=1): stage_sin=0, mac_sel=0, mac_busy=0, mac_done=0, pend=0, overrun=0, sample counter scnt=0, FSM=IDLE. Asserting rst mid-burst aborts the burst immediately and drops all pending requests.
- Sample counter: scnt is NSTAGE bits wide. On sample_in&&en, scnt_next = scnt+1, with wrap-around. Requests raised on that edge: stage 0 always; stage k≥1 when scnt_next[k-1:0]==0.
- Request latching: a raised request sets pend[k]. If pend[k] is already 1 and is not being cleared this cycle, set overrun[k] and merge the request (no queue depth).
- Grant clearing pend[k] in the same cycle as a new request for k: the set wins, pend[k] stays 1, and no overrun is flagged.
- sample_in with en=0 is ignored: scnt does not change and no requests are raised. Pending requests and any in-flight burst still complete.
- ovr_clr clears overrun on the next edge. A simultaneous new overrun wins, and that bit stays 1.
- FSM states:
  - IDLE: if pend!=0, go to GRANT; otherwise stay in IDLE.
  - GRANT (1 cycle): select the lowest-index set bit of pend (fixed priority). Pulse stage_sin[idx]. mac_sel<=idx. Clear pend[idx]. mac_busy<=1. Load bcnt=BURST_LEN-1. Go to BURST.
  - BURST: decrement bcnt each cycle. When bcnt==0, pulse mac_done, mac_busy<=0, go to IDLE.
- Latency: request latched at edge N → stage_sin at cycle N+2 (IDLE→GRANT, then strobe) when the datapath is idle. Spacing between consecutive stage_sin pulses is BURST_LEN+2 cycles.
- stage_sin and mac_done are registered outputs, never high for two consecutive cycles. At most one stage_sin bit is high at a time.

Optional Feature:
Macro TAU_STAGE_SCHED_RR_EN.
- Defined: round-robin arbitration. Search starts at (last granted index + 1) mod NSTAGE. The last granted index resets to NSTAGE-1, so the first grant searches from stage 0.
- Undefined: fixed priority, lowest index wins.
- All other timing is identical in both builds.

Test Plan:
All scenarios use NSTAGE=4, BURST_LEN=8, fixed priority unless stated.
1. Reset, en=1, one sample_in → pend=0001; stage_sin=0001 two cycles later; mac_busy high 8 cycles; mac_done on the 8th; overrun=0.
2. Eight samples spaced 20 cycles apart → every 2nd sample raises stage 1, every 4th raises stage 2, the 8th raises stage 3. On the 8th, pend=1111 and grants go in order 0,1,2,3, each 10 cycles apart.
3. Two samples 3 cycles apart while stage 0 is bursting → second request merges and overrun=0001. Then ovr_clr → overrun=0000 next cycle.
4. Assert rst at cycle 4 of a burst with pend=0110 → all outputs return to reset values immediately; after release, no stage_sin until a new sample_in.
5. en=0 with sample_in pulses → scnt, pend and stage_sin are unchanged; an in-flight burst still completes with mac_done.
6. With TAU_STAGE_SCHED_RR_EN defined, pend=1111 held continuously → grant order 0,1,2,3,0,…; without it, stage 0 starves the other stages.
